i2c_sequencer: RTL and testbench
================================

# i2c_sequencer

Command sequencer that sits directly upstream of the I2C byte engine. It accepts queued byte commands from the host-side register logic and presents them to the engine with the correct start/stop/read/ack controls. It holds the engine in reset while idle and returns the received byte and sampled ACK bit for every completed byte.

## Interface
- DEPTH, 4: command FIFO depth; power of two, minimum 2.
- clock  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host offers a command.
- cmd_ready  out  1  FIFO not full (and not aborted, see Configuration).
- cmd_byte  in  8  byte to write; ignored for reads.
- cmd_flags  in  4  [3] start, [2] stop, [1] read, [0] drive_ack (master ACK on read).
- res_valid  out  1  one-cycle pulse per completed byte.
- res_byte  out  8  byte captured from the engine.
- res_ack  out  1  sampled ACK bit: 0 = ACK, 1 = NACK.
- nack_seen  out  1  sticky; set by a NACK on a write byte.
- clr  in  1  synchronous clear of nack_seen and aborted.
- busy  out  1  engine running or FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- eng_nreset  out  1  registered reset to the engine.
- eng_write_byte, eng_read_mode, eng_drive_ack, eng_do_start, eng_do_stop  out  8/1/1/1/1  engine controls.
- eng_read_byte  in  8, eng_ack  in  1, eng_finished  in  1  engine results.

## Operation
- Push occurs when cmd_valid && cmd_ready. Push is never accepted while full and there is no bypass.
- FSM states:
  - IDLE: eng_nreset=0. When the FIFO is non-empty, pop the head into the cur register, set eng_nreset<=1, go to RUN.
  - RUN: engine controls come from cur. On eng_finished=1:
    - register res_byte/res_ack; res_valid pulses on the next cycle;
    - if the FIFO is non-empty, pop the head into cur and stay in RUN (no reset gap);
    - if the FIFO is empty, set eng_nreset<=0 and go to IDLE.
- Look-ahead mux: the engine samples its controls on the edge right after finished. While in RUN with eng_finished=1, the engine controls are driven combinationally:
  - from the FIFO head if the FIFO is non-empty;
  - otherwise from idle fields: do_start=1, all other controls 0, write_byte=0xFF.
- In all other cycles the controls come from cur.
- Underrun: FIFO empty at finished on a byte without stop. The sequencer still returns to IDLE and SCL/SDA are left released; the host is responsible for queueing stop correctly.
- nack_seen is set when res_ack=1 and the completed command was a write. A simultaneous clr loses to set.

## Timing
- Reset values: cmd_ready=1, res_valid=0, res_byte=0, res_ack=0, nack_seen=0, busy=0, level=0, eng_nreset=0.
- Launch: a push at edge e0 makes level=1 at e0, pops into cur at e1 (eng_nreset=1), and the engine's first active edge is e2.
- Result: eng_finished high in cycle t gives res_valid high during cycle t+1 only.
- Simultaneous push and pop in one cycle is legal; level is unchanged.
- nreset low mid-byte empties the FIFO, returns the FSM to IDLE and asserts eng_nreset immediately (the engine releases the bus). Results in flight are discarded.

## Configuration
- I2C_SEQ_NACK_ABORT_EN defined:
  - a write-byte NACK flushes the FIFO on the same edge the result is registered, and the FSM returns to IDLE;
  - an internal aborted flag holds cmd_ready=0 until clr.
- Not defined: NACK only sets nack_seen, and queued commands continue.

## Structure
- Package i2c_pkg holds the flag bit-index constants (START, STOP, READ, DRIVE_ACK), the FSM state encoding and the idle-field constants.
- Sub-module i2c_cmd_fifo: synchronous FIFO, 12-bit entries, DEPTH deep, with head look-ahead output, full/empty flags and level.

## Test plan
- Push 0xA0 with flags start|stop; slave ACKs. Expect eng_write_byte=0xA0, one res_valid pulse with res_ack=0, then busy=0 and eng_nreset=0.
- Push a read with flags stop while the slave drives 0x5A. Expect res_byte=0x5A, eng_drive_ack=0 and a single result.
- With DEPTH=4, push 5 commands back-to-back (start, write ×2, read, read|stop|drive_ack). Expect cmd_ready=0 at level=4, results returned in order, and eng_nreset never low between bytes.
- Slave NACKs the second of three writes. Expect nack_seen=1 and clr clearing it. With the macro defined, also expect the third write dropped, level=0 and cmd_ready=0 until clr.
- Assert nreset during bit 4 of a write. Expect eng_nreset=0 immediately, level=0, no res_valid, and all reset values restored.
- Engine finished arrives with the FIFO empty and the last byte lacking stop. Expect idle fields presented for that cycle (do_start=1), then IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: flag bit positions,
// command entry layout, FSM encoding and the control fields used while parking.
package i2c_pkg;

  localparam int FLAG_START     = 3;
  localparam int FLAG_STOP      = 2;
  localparam int FLAG_READ      = 1;
  localparam int FLAG_DRIVE_ACK = 0;

  localparam int CMD_W = 12;

  typedef struct packed {
    logic [3:0] flags;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Presented for the one cycle in which the engine is about to be parked
  localparam logic [7:0] IDLE_WRITE_BYTE = 8'hFF;
  localparam logic [3:0] IDLE_FLAGS      = 4'b1000;
  localparam cmd_t       IDLE_CMD        = '{flags: IDLE_FLAGS, data: IDLE_WRITE_BYTE};

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with a look-ahead head output, full/empty flags,
// occupancy level and a synchronous flush that wins over a same-cycle push.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Extra pointer bit distinguishes a full ring from an empty one
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2c_sequencer.sv
// Feeds queued byte commands to the I2C byte engine and returns per-byte results.
// Optional macro I2C_SEQ_NACK_ABORT_EN: a write NACK flushes the queue and blocks pushes until clr.
module i2c_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_byte,
  input  logic [3:0]             cmd_flags,
  output logic                   res_valid,
  output logic [7:0]             res_byte,
  output logic                   res_ack,
  output logic                   nack_seen,
  input  logic                   clr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   eng_nreset,
  output logic [7:0]             eng_write_byte,
  output logic                   eng_read_mode,
  output logic                   eng_drive_ack,
  output logic                   eng_do_start,
  output logic                   eng_do_stop,
  input  logic [7:0]             eng_read_byte,
  input  logic                   eng_ack,
  input  logic                   eng_finished
);

  seq_state_t state, state_nxt;
  cmd_t       cur, cur_nxt, head, cmd_in, ctrl;
  logic       eng_nreset_nxt;
  logic       full, empty, push, pop;
  logic       byte_done, write_nack, abort_hit;

  assign byte_done  = (state == ST_RUN) && eng_finished;
  assign write_nack = byte_done && eng_ack && !cur.flags[FLAG_READ];

`ifdef I2C_SEQ_NACK_ABORT_EN
  logic aborted;

  assign abort_hit = write_nack;
  assign cmd_ready = !full && !aborted;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)        aborted <= 1'b0;
    else if (abort_hit) aborted <= 1'b1;
    else if (clr)       aborted <= 1'b0;
  end
`else
  assign abort_hit = 1'b0;
  assign cmd_ready = !full;
`endif

  assign push   = cmd_valid && cmd_ready;
  assign cmd_in = '{flags: cmd_flags, data: cmd_byte};
  assign busy   = (state == ST_RUN) || !empty;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .flush     (abort_hit),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    eng_nreset_nxt = eng_nreset;
    pop            = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop            = 1'b1;
          cur_nxt        = head;
          eng_nreset_nxt = 1'b1;
          state_nxt      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (eng_finished) begin
          if (abort_hit || empty) begin
            eng_nreset_nxt = 1'b0;
            state_nxt      = ST_IDLE;
          end else begin
            pop     = 1'b1;
            cur_nxt = head;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The engine samples its next controls on the edge that ends a byte, so
  // during that cycle it must already see what cur is about to become.
  always_comb begin
    ctrl = cur;
    if (byte_done) ctrl = empty ? IDLE_CMD : head;
  end

  assign eng_write_byte = ctrl.data;
  assign eng_do_start   = ctrl.flags[FLAG_START];
  assign eng_do_stop    = ctrl.flags[FLAG_STOP];
  assign eng_read_mode  = ctrl.flags[FLAG_READ];
  assign eng_drive_ack  = ctrl.flags[FLAG_DRIVE_ACK];

  // NOTE: state is updated with non-blocking assignments so every register
  // here samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      cur        <= '0;
      eng_nreset <= 1'b0;
      res_valid  <= 1'b0;
      res_byte   <= '0;
      res_ack    <= 1'b0;
      nack_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      eng_nreset <= eng_nreset_nxt;
      res_valid  <= byte_done;
      if (byte_done) begin
        res_byte <= eng_read_byte;
        res_ack  <= eng_ack;
      end
      if (write_nack) nack_seen <= 1'b1;
      else if (clr)   nack_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_sequencer.sv
// Self-checking bench for i2c_sequencer: behavioural byte-engine stand-in plus a
// command-queue reference model; honours I2C_SEQ_NACK_ABORT_EN when defined.
`timescale 1ns/1ps
module tb_i2c_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    bit       start;
    bit       stop;
    bit       read;
    bit       drv_ack;
    bit [7:0] data;
  } tcmd_t;

  localparam tcmd_t IDLE_T = '{start: 1'b1, stop: 1'b0, read: 1'b0, drv_ack: 1'b0, data: 8'hFF};

  logic          clock;
  logic          nreset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_byte;
  logic [3:0]    cmd_flags;
  logic          res_valid;
  logic [7:0]    res_byte;
  logic          res_ack;
  logic          nack_seen;
  logic          clr;
  logic          busy;
  logic [LW-1:0] level;
  logic          eng_nreset;
  logic [7:0]    eng_write_byte;
  logic          eng_read_mode;
  logic          eng_drive_ack;
  logic          eng_do_start;
  logic          eng_do_stop;
  logic [7:0]    eng_read_byte;
  logic          eng_ack;
  logic          eng_finished;

  i2c_sequencer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_byte       (cmd_byte),
    .cmd_flags      (cmd_flags),
    .res_valid      (res_valid),
    .res_byte       (res_byte),
    .res_ack        (res_ack),
    .nack_seen      (nack_seen),
    .clr            (clr),
    .busy           (busy),
    .level          (level),
    .eng_nreset     (eng_nreset),
    .eng_write_byte (eng_write_byte),
    .eng_read_mode  (eng_read_mode),
    .eng_drive_ack  (eng_drive_ack),
    .eng_do_start   (eng_do_start),
    .eng_do_stop    (eng_do_stop),
    .eng_read_byte  (eng_read_byte),
    .eng_ack        (eng_ack),
    .eng_finished   (eng_finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: commands accepted but not yet started, in order
  tcmd_t model_q[$];
  bit    model_nack;
  int    n_started, n_results, resets_seen, idle_looks;

  // Engine stand-in state and per-test knobs
  bit         eng_active, fin_prev, res_pending, abort_now, ack_v;
  tcmd_t      look, cur_cmd;
  int         remaining;
  logic [7:0] exp_byte;
  logic       exp_ack;
  int         byte_len       = 0;
  int         fixed_data     = -1;
  int         nack_countdown = -1;

  function automatic tcmd_t sample_ctrl();
    return '{start: eng_do_start, stop: eng_do_stop, read: eng_read_mode,
             drv_ack: eng_drive_ack, data: eng_write_byte};
  endfunction

  task automatic start_byte(input tcmd_t seen);
    tcmd_t e;
    if (model_q.size() == 0) begin
      check("unexpected_start", 32'(seen), 32'hFFFF_FFFF);
    end else begin
      e = model_q.pop_front();
      check("start_ctrl", 32'(seen), 32'(e));
    end
    cur_cmd   = seen;
    remaining = (byte_len > 0) ? byte_len : int'($urandom_range(2, 6));
    n_started++;
  endtask

  // Engine model: acts on negedges, samples controls where the real engine would
  initial begin
    eng_finished  = 1'b0;
    eng_read_byte = 8'h00;
    eng_ack       = 1'b0;
    forever begin
      @(negedge clock);
      if (!nreset) begin
        eng_active   = 1'b0;
        fin_prev     = 1'b0;
        res_pending  = 1'b0;
        abort_now    = 1'b0;
        eng_finished = 1'b0;
        continue;
      end
      if (res_pending) begin
        check("res_valid",  32'(res_valid), 32'd1);
        check("res_byte",   32'(res_byte),  32'(exp_byte));
        check("res_ack",    32'(res_ack),   32'(exp_ack));
        check("nack_seen",  32'(nack_seen), 32'(model_nack));
        res_pending = 1'b0;
        n_results++;
      end else begin
        check("res_valid_quiet", 32'(res_valid), 32'd0);
      end
      if (fin_prev) begin
        fin_prev     = 1'b0;
        eng_finished = 1'b0;
        if (eng_nreset) begin
          start_byte(look);
        end else begin
          eng_active = 1'b0;
          resets_seen++;
          if (!abort_now) begin
            check("idle_fields", 32'(look), 32'(IDLE_T));
            idle_looks++;
          end
          abort_now = 1'b0;
        end
      end else if (!eng_nreset) begin
        if (eng_active) resets_seen++;
        eng_active = 1'b0;
      end else if (!eng_active) begin
        eng_active = 1'b1;
        start_byte(sample_ctrl());
      end else begin
        remaining--;
        if (remaining <= 0) begin
          if (cur_cmd.read) begin
            ack_v = 1'($urandom_range(0, 1));
          end else if (nack_countdown == 0) begin
            ack_v          = 1'b1;
            nack_countdown = -1;
          end else begin
            ack_v = 1'b0;
            if (nack_countdown > 0) nack_countdown--;
          end
          eng_read_byte = (fixed_data >= 0) ? fixed_data[7:0] : 8'($urandom);
          eng_ack       = ack_v;
          eng_finished  = 1'b1;
          fin_prev      = 1'b1;
          res_pending   = 1'b1;
          exp_byte      = eng_read_byte;
          exp_ack       = ack_v;
          if (!cur_cmd.read && ack_v) begin
            model_nack = 1'b1;
`ifdef I2C_SEQ_NACK_ABORT_EN
            abort_now = 1'b1;
`endif
          end
          #1;
          look = sample_ctrl();
          if (abort_now) model_q.delete();
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge with cmd_valid low
  task automatic push_cmd(input bit [3:0] fl, input bit [7:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_flags = fl;
    cmd_byte  = d;
    model_q.push_back(tcmd_t'({fl, d}));
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      #2;
      n++;
    end while ((busy || eng_active || fin_prev || res_pending || model_q.size() != 0) && n < 1000);
    check("idle_reached", 32'(n < 1000), 32'd1);
    @(negedge clock);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clock);
    clr        = 1'b0;
    model_nack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, f0, i0;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    cmd_flags = 4'h0;
    clr       = 1'b0;
    nreset    = 1'b1;
    #1 nreset = 1'b0;
    #2;
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_byte",   32'(res_byte),   32'd0);
    check("rst_res_ack",    32'(res_ack),    32'd0);
    check("rst_nack_seen",  32'(nack_seen),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_level",      32'(level),      32'd0);
    check("rst_eng_nreset", 32'(eng_nreset), 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    // Single write with start|stop, slave ACKs
    byte_len = 4;
    r0 = n_results;
    push_cmd(4'b1100, 8'hA0);
    wait_idle();
    check("t1_busy",       32'(busy),         32'd0);
    check("t1_eng_nreset", 32'(eng_nreset),   32'd0);
    check("t1_results",    32'(n_results - r0), 32'd1);

    // Read with stop, slave returns 0x5A
    fixed_data = 8'h5A;
    r0 = n_results;
    push_cmd(4'b0110, 8'h00);
    wait_idle();
    fixed_data = -1;
    check("t2_res_byte", 32'(res_byte),        32'h5A);
    check("t2_results",  32'(n_results - r0),  32'd1);

    // Five back-to-back commands against a four-deep queue
    byte_len = 6;
    r0 = n_results;
    f0 = resets_seen;
    push_cmd(4'b1000, 8'hA0);
    push_cmd(4'b0000, 8'h11);
    push_cmd(4'b0000, 8'h22);
    push_cmd(4'b0010, 8'h00);
    push_cmd(4'b0111, 8'h00);
    check("t3_level_full", 32'(level),     32'd4);
    check("t3_ready_low",  32'(cmd_ready), 32'd0);
    byte_len = 0;
    wait_idle();
    check("t3_results",    32'(n_results - r0),   32'd5);
    check("t3_no_gap",     32'(resets_seen - f0), 32'd1);

    // Second of three writes NACKed
    byte_len       = 6;
    nack_countdown = 1;
    s0 = n_started;
    push_cmd(4'b1000, 8'hA2);
    push_cmd(4'b0000, 8'h33);
    push_cmd(4'b0100, 8'h44);
    wait_idle();
    check("t4_nack_seen", 32'(nack_seen), 32'd1);
`ifdef I2C_SEQ_NACK_ABORT_EN
    check("t4_level",     32'(level),            32'd0);
    check("t4_ready_low", 32'(cmd_ready),        32'd0);
    check("t4_started",   32'(n_started - s0),   32'd2);
`else
    check("t4_ready",     32'(cmd_ready),        32'd1);
    check("t4_started",   32'(n_started - s0),   32'd3);
`endif
    pulse_clr();
    check("t4_nack_clr",  32'(nack_seen), 32'd0);
    check("t4_ready_clr", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a long byte with another command queued
    byte_len = 18;
    s0 = n_started;
    push_cmd(4'b1000, 8'hB5);
    push_cmd(4'b0100, 8'hC6);
    for (int n = 0; n < 50 && n_started == s0; n++) @(negedge clock);
    check("t5_started", 32'(n_started - s0), 32'd1);
    repeat (8) @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    check("t5_eng_nreset", 32'(eng_nreset), 32'd0);
    check("t5_level",      32'(level),      32'd0);
    check("t5_busy",       32'(busy),       32'd0);
    check("t5_res_valid",  32'(res_valid),  32'd0);
    check("t5_cmd_ready",  32'(cmd_ready),  32'd1);
    check("t5_res_byte",   32'(res_byte),   32'd0);
    check("t5_nack_seen",  32'(nack_seen),  32'd0);
    model_q.delete();
    @(negedge clock);
    @(negedge clock);
    nreset   = 1'b1;
    byte_len = 0;
    repeat (5) @(negedge clock);
    check("t5_still_idle", 32'(busy), 32'd0);

    // Underrun: last byte lacks stop and nothing follows it
    i0 = idle_looks;
    push_cmd(4'b1000, 8'hD7);
    wait_idle();
    check("t6_idle_look",  32'(idle_looks - i0), 32'd1);
    check("t6_eng_nreset", 32'(eng_nreset),      32'd0);

    // Random commands with random gaps and byte lengths
    r0 = n_results;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      push_cmd(4'($urandom), 8'($urandom));
    end
    wait_idle();
    check("rand_results", 32'(n_results - r0), 32'd40);
    check("rand_busy",    32'(busy),           32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
